noi_tiep_thu_khung: RTL and testbench

- Serial frame receiver sitting directly downstream of the serial-in/serial-out shift register; its s_in is driven by that register's s_out.
- Watches the idle-high serial line for a start bit and samples each bit at mid-bit. It deserialises DATA_W data bits (LSB first), checks an even parity bit and a stop bit.
- Presents the byte in parallel with a one-cycle valid strobe plus error flags.

---
 rtl/noi_tiep_thu_khung.sv | 115 +++++++++++
 tb/tb_noi_tiep_thu_khung.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/noi_tiep_thu_khung.sv
// rtl/noi_tiep_thu_khung.sv - serial frame receiver: start, DATA_W data bits LSB first, even parity, stop
module noi_tiep_thu_khung #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DATA_W + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] PARITY    = 3'd3;
    localparam logic [2:0] STOP      = 3'd4;
    localparam logic [2:0] WAIT_IDLE = 3'd5;

    logic [2:0]        state;
    logic [CW-1:0]     cyc_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_next;
    logic              perr;
    logic              sample;

    // The start bit is sampled half a bit in; every later bit a full bit after the previous sample.
    assign sample = (state == START) ? (cyc_cnt == HALF_LAST) : (cyc_cnt == BIT_LAST);
    assign busy   = (state != IDLE);

    always_comb begin
        shreg_next             = shreg >> 1;
        shreg_next[DATA_W-1]   = s_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            perr       <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!s_in) begin
                        state   <= START;
                        cyc_cnt <= '0;
                    end
                end
                WAIT_IDLE: begin
                    if (s_in) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    if (sample) begin
                        cyc_cnt <= '0;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                    if (sample) begin
                        case (state)
                            START: begin
                                if (s_in) begin
                                    state <= IDLE;
                                end else begin
                                    state   <= DATA;
                                    bit_cnt <= '0;
                                end
                            end
                            DATA: begin
                                shreg <= shreg_next;
                                if (bit_cnt == DATA_LAST) begin
                                    state <= PARITY;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                            PARITY: begin
                                perr  <= s_in ^ (^shreg);
                                state <= STOP;
                            end
                            STOP: begin
                                data_out   <= shreg;
                                parity_err <= perr;
                                frame_err  <= ~s_in;
                                data_valid <= 1'b1;
                                // A low stop bit may be a stuck line; wait for it to go high before hunting again.
                                state      <= s_in ? IDLE : WAIT_IDLE;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_noi_tiep_thu_khung.sv
// tb/tb_noi_tiep_thu_khung.sv - scoreboard bench for noi_tiep_thu_khung
module tb_noi_tiep_thu_khung;
    localparam int DATA_W = 8;
    localparam int CPB    = 4;
    localparam int HALF   = CPB / 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              s_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    noi_tiep_thu_khung #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .s_in(s_in), .data_out(data_out),
        .data_valid(data_valid), .parity_err(parity_err),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              perr;
        logic              ferr;
        int                t;
    } exp_t;

    exp_t q[$];
    exp_t got_e;
    int   cyc        = 0;
    int   chk_cnt    = 0;
    int   pass_cnt   = 0;
    int   pulses     = 0;
    int   exp_pulses = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        chk_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s got=%0h want=%0h", name, got, want);
    endtask

    // Monitor: pops an expectation for each data_valid pulse seen.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (data_valid === 1'b1) begin
            pulses++;
            if (q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                got_e = q.pop_front();
                check("data_out", 32'(data_out), 32'(got_e.data));
                check("parity_err", 32'(parity_err), 32'(got_e.perr));
                check("frame_err", 32'(frame_err), 32'(got_e.ferr));
                check("valid_cycle", 32'(cyc), 32'(got_e.t));
            end
        end
    end

    task automatic hold(input logic b, input int n);
        s_in = b;
        repeat (n) @(negedge clk);
    endtask

    // Send one frame starting at the current negedge; pflip inverts the correct parity bit.
    task automatic send_frame(input logic [DATA_W-1:0] d, input logic pflip,
                              input logic stop, input int low_after);
        exp_t e;
        int   ones = 0;
        logic pbit;
        for (int i = 0; i < DATA_W; i++) ones += int'(d[i]);
        pbit   = logic'(ones % 2) ^ pflip;
        e.data = d;
        e.perr = (pbit != logic'(ones % 2));
        e.ferr = ~stop;
        e.t    = cyc + 1 + HALF + (DATA_W + 2) * CPB;
        q.push_back(e);
        exp_pulses++;
        hold(1'b0, CPB);
        for (int i = 0; i < DATA_W; i++) hold(d[i], CPB);
        hold(pbit, CPB);
        hold(stop, CPB);
        if (stop) begin
            check("busy_after_frame", 32'(busy), 32'd0);
        end else begin
            hold(1'b0, low_after);
            check("busy_wait_idle", 32'(busy), 32'd1);
            hold(1'b1, CPB);
            check("busy_after_ferr", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1;
        s_in  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_in = logic'(i % 2);
            @(negedge clk);
            check("reset_outs", {data_out, data_valid, parity_err, frame_err, busy}, 32'd0);
        end
        reset = 1'b0;
        hold(1'b1, 3);
        check("post_reset_outs", {data_out, data_valid, parity_err, frame_err, busy}, 32'd0);

        send_frame(8'hA5, 1'b0, 1'b1, 0);
        hold(1'b1, 2);
        send_frame(8'h01, 1'b1, 1'b1, 0);
        hold(1'b1, 2);
        send_frame(8'h3C, 1'b0, 1'b0, 8);
        hold(1'b1, 2);

        // Single-clock glitch must be rejected at the start-bit sample.
        hold(1'b0, 1);
        hold(1'b1, 2 * CPB);
        check("glitch_busy", 32'(busy), 32'd0);

        // Reset in the middle of a 0xFF frame.
        hold(1'b0, CPB);
        for (int i = 0; i < 3; i++) hold(1'b1, CPB);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort_outs", {data_out, data_valid, parity_err, frame_err, busy}, 32'd0);
        reset = 1'b0;
        hold(1'b1, CPB);
        send_frame(8'h5A, 1'b0, 1'b1, 0);

        // Back-to-back frames, no idle gap.
        send_frame(8'h00, 1'b0, 1'b1, 0);
        send_frame(8'hFF, 1'b0, 1'b1, 0);
        hold(1'b1, 2);

        for (int n = 0; n < 40; n++) begin
            send_frame(DATA_W'($urandom), ($urandom_range(0, 4) == 0),
                       ($urandom_range(0, 4) != 0), int'($urandom_range(0, 6)));
            hold(1'b1, int'($urandom_range(0, 3)));
        end

        hold(1'b1, 10);
        check("queue_empty", 32'(q.size()), 32'd0);
        check("pulse_count", 32'(pulses), 32'(exp_pulses));
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
